// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: operator codes, widths and the entry record.
// The age field is only meaningful when the design is built with RS_AGE_ORDER_EN.
package alu_reservation_station_pkg;

    localparam int DATA_W    = 32;
    localparam int ROB_IDX_W = 4;
    localparam int OP_W      = 6;
    localparam int RS_DEPTH  = 16;
    localparam int RS_IDX_W  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_SLTIU = 6'd13,
        OP_XORI  = 6'd14,
        OP_ORI   = 6'd15,
        OP_ANDI  = 6'd16,
        OP_SLLI  = 6'd17,
        OP_SRLI  = 6'd18,
        OP_SRAI  = 6'd19,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21,
        OP_SLL   = 6'd22,
        OP_SLT   = 6'd23,
        OP_SLTU  = 6'd24,
        OP_XOR   = 6'd25,
        OP_SRL   = 6'd26,
        OP_SRA   = 6'd27,
        OP_OR    = 6'd28,
        OP_AND   = 6'd29
    } alu_op_e;

    typedef struct packed {
        logic                 valid;
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    vj;
        logic [DATA_W-1:0]    vk;
        logic [ROB_IDX_W-1:0] qj;
        logic [ROB_IDX_W-1:0] qk;
        logic                 rj;
        logic                 rk;
        logic [ROB_IDX_W-1:0] reorder;
        logic [RS_IDX_W-1:0]  age;
    } rs_entry_t;

    function automatic logic [RS_IDX_W-1:0] age_inc(input logic [RS_IDX_W-1:0] age);
        return (&age) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/alu_reservation_station_rs_select.sv
// Combinational picker: highest age among requesters, ties to the lowest index.
// With all ages zero it degenerates to a plain lowest-index priority encoder.
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = 4,
    parameter int AGE_W = 4
) (
    input  logic [N-1:0]            i_req,
    input  logic [N-1:0][AGE_W-1:0] i_age,
    output logic                    o_found,
    output logic [IDX_W-1:0]        o_idx
);

    logic [AGE_W-1:0] w_best;

    // Scan downward so that >= hands equal ages to the lower index.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_best  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i] && (!o_found || i_age[i] >= w_best)) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
                w_best  = i_age[i];
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until operands arrive via CDB snoop, issues one per cycle.
// Define RS_AGE_ORDER_EN to select the oldest ready entry instead of the lowest-index one.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_DEPTH = alu_reservation_station_pkg::RS_DEPTH,
    parameter int RS_IDX_W = alu_reservation_station_pkg::RS_IDX_W
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_rdy,
    input  logic                 in_flush,
    input  logic                 in_dispatch_valid,
    input  logic [OP_W-1:0]      in_dispatch_op,
    input  logic [DATA_W-1:0]    in_dispatch_pc,
    input  logic [DATA_W-1:0]    in_dispatch_imm,
    input  logic [DATA_W-1:0]    in_dispatch_vj,
    input  logic [DATA_W-1:0]    in_dispatch_vk,
    input  logic [ROB_IDX_W-1:0] in_dispatch_qj,
    input  logic [ROB_IDX_W-1:0] in_dispatch_qk,
    input  logic                 in_dispatch_rj,
    input  logic                 in_dispatch_rk,
    input  logic [ROB_IDX_W-1:0] in_dispatch_reorder,
    output logic                 out_full,
    input  logic                 in_cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] in_cdb_alu_reorder,
    input  logic [DATA_W-1:0]    in_cdb_alu_result,
    input  logic                 in_cdb_lsb_valid,
    input  logic [ROB_IDX_W-1:0] in_cdb_lsb_reorder,
    input  logic [DATA_W-1:0]    in_cdb_lsb_result,
    output logic                 out_alu_enable,
    output logic [OP_W-1:0]      out_alu_op,
    output logic [DATA_W-1:0]    out_alu_pc,
    output logic [DATA_W-1:0]    out_alu_imm,
    output logic [DATA_W-1:0]    out_alu_rs,
    output logic [DATA_W-1:0]    out_alu_rt,
    output logic [ROB_IDX_W-1:0] out_alu_reorder
);

    rs_entry_t [RS_DEPTH-1:0]                r_ent;
    rs_entry_t [RS_DEPTH-1:0]                w_nxt;
    rs_entry_t                               w_disp;
    logic      [RS_DEPTH-1:0]                w_valid;
    logic      [RS_DEPTH-1:0]                w_ready;
    logic      [RS_DEPTH-1:0][RS_IDX_W-1:0]  w_age;
    logic                                    w_iss_found;
    logic      [RS_IDX_W-1:0]                w_iss_idx;
    logic                                    w_free_found;
    logic      [RS_IDX_W-1:0]                w_free_idx;
    logic                                    r_alu_enable;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_valid[i] = r_ent[i].valid;
            w_ready[i] = r_ent[i].valid & r_ent[i].rj & r_ent[i].rk;
            w_age[i]   = r_ent[i].age;
        end
    end

    rs_select #(.N(RS_DEPTH), .IDX_W(RS_IDX_W), .AGE_W(RS_IDX_W)) u_issue_sel (
        .i_req   (w_ready),
        .i_age   (w_age),
        .o_found (w_iss_found),
        .o_idx   (w_iss_idx)
    );

    rs_select #(.N(RS_DEPTH), .IDX_W(RS_IDX_W), .AGE_W(RS_IDX_W)) u_free_sel (
        .i_req   (~w_valid),
        .i_age   ('0),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    assign out_full       = &w_valid;
    assign out_alu_enable = r_alu_enable & in_rdy;

    // New entry, with same-cycle CDB bypass for operands still pending (ALU port wins).
    always_comb begin
        w_disp         = '0;
        w_disp.valid   = 1'b1;
        w_disp.op      = in_dispatch_op;
        w_disp.pc      = in_dispatch_pc;
        w_disp.imm     = in_dispatch_imm;
        w_disp.vj      = in_dispatch_vj;
        w_disp.vk      = in_dispatch_vk;
        w_disp.qj      = in_dispatch_qj;
        w_disp.qk      = in_dispatch_qk;
        w_disp.rj      = in_dispatch_rj;
        w_disp.rk      = in_dispatch_rk;
        w_disp.reorder = in_dispatch_reorder;
        if (!in_dispatch_rj) begin
            if (in_cdb_alu_valid && in_cdb_alu_reorder == in_dispatch_qj) begin
                w_disp.vj = in_cdb_alu_result;
                w_disp.rj = 1'b1;
            end else if (in_cdb_lsb_valid && in_cdb_lsb_reorder == in_dispatch_qj) begin
                w_disp.vj = in_cdb_lsb_result;
                w_disp.rj = 1'b1;
            end
        end
        if (!in_dispatch_rk) begin
            if (in_cdb_alu_valid && in_cdb_alu_reorder == in_dispatch_qk) begin
                w_disp.vk = in_cdb_alu_result;
                w_disp.rk = 1'b1;
            end else if (in_cdb_lsb_valid && in_cdb_lsb_reorder == in_dispatch_qk) begin
                w_disp.vk = in_cdb_lsb_result;
                w_disp.rk = 1'b1;
            end
        end
    end

    // Wakeup, ageing, issue free and allocation; all decisions use pre-edge state.
    always_comb begin
        w_nxt = r_ent;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (r_ent[i].valid && !r_ent[i].rj) begin
                if (in_cdb_alu_valid && in_cdb_alu_reorder == r_ent[i].qj) begin
                    w_nxt[i].vj = in_cdb_alu_result;
                    w_nxt[i].rj = 1'b1;
                end else if (in_cdb_lsb_valid && in_cdb_lsb_reorder == r_ent[i].qj) begin
                    w_nxt[i].vj = in_cdb_lsb_result;
                    w_nxt[i].rj = 1'b1;
                end
            end
            if (r_ent[i].valid && !r_ent[i].rk) begin
                if (in_cdb_alu_valid && in_cdb_alu_reorder == r_ent[i].qk) begin
                    w_nxt[i].vk = in_cdb_alu_result;
                    w_nxt[i].rk = 1'b1;
                end else if (in_cdb_lsb_valid && in_cdb_lsb_reorder == r_ent[i].qk) begin
                    w_nxt[i].vk = in_cdb_lsb_result;
                    w_nxt[i].rk = 1'b1;
                end
            end
`ifdef RS_AGE_ORDER_EN
            if (r_ent[i].valid) begin
                w_nxt[i].age = age_inc(r_ent[i].age);
            end
`endif
        end
        if (w_iss_found) begin
            w_nxt[w_iss_idx].valid = 1'b0;
        end
        if (in_dispatch_valid && w_free_found) begin
            w_nxt[w_free_idx] = w_disp;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_ent           <= '0;
            r_alu_enable    <= 1'b0;
            out_alu_op      <= '0;
            out_alu_pc      <= '0;
            out_alu_imm     <= '0;
            out_alu_rs      <= '0;
            out_alu_rt      <= '0;
            out_alu_reorder <= '0;
        end else if (in_rdy) begin
            if (in_flush) begin
                r_ent        <= '0;
                r_alu_enable <= 1'b0;
            end else begin
                r_ent        <= w_nxt;
                r_alu_enable <= w_iss_found;
                if (w_iss_found) begin
                    out_alu_op      <= r_ent[w_iss_idx].op;
                    out_alu_pc      <= r_ent[w_iss_idx].pc;
                    out_alu_imm     <= r_ent[w_iss_idx].imm;
                    out_alu_rs      <= r_ent[w_iss_idx].vj;
                    out_alu_rt      <= r_ent[w_iss_idx].vk;
                    out_alu_reorder <= r_ent[w_iss_idx].reorder;
                end
            end
        end
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Holds decoded ALU/branch/jump instructions after dispatch until both source operands are valid.
- Snoops the two CDB ports (ALU result, LSB result) to wake waiting operands.
- Issues at most one ready entry per cycle to the ALU stage as a registered enable plus operand bundle.
- Sits between the dispatcher and the ALU, which broadcasts on the CDB that this block itself snoops.

Parameters:
- RS_DEPTH, 16, number of entries (power of two, at least 2)
- RS_IDX_W, 4, log2(RS_DEPTH)
- ROB_IDX_W, 4, ROB tag width
- OP_W, 6, operator code width
- DATA_W, 32, data/address width

Ports:
- in_clk  input  1  clock; all state changes on the rising edge
- in_rst  input  1  reset; asynchronous, active-low (in_rst==0 resets)
- in_rdy  input  1  global enable; 0 freezes all state
- in_flush  input  1  misprediction flush from the ROB
- in_dispatch_valid  input  1  dispatch request
- in_dispatch_op  input  OP_W  operator code
- in_dispatch_pc  input  DATA_W  instruction PC
- in_dispatch_imm  input  DATA_W  sign-extended immediate
- in_dispatch_vj / in_dispatch_vk  input  DATA_W  operand values
- in_dispatch_qj / in_dispatch_qk  input  ROB_IDX_W  producer tags
- in_dispatch_rj / in_dispatch_rk  input  1  operand already valid
- in_dispatch_reorder  input  ROB_IDX_W  destination ROB tag
- out_full  output  1  no free entry
- in_cdb_alu_valid, in_cdb_alu_reorder, in_cdb_alu_result  input  1/ROB_IDX_W/DATA_W  ALU CDB snoop
- in_cdb_lsb_valid, in_cdb_lsb_reorder, in_cdb_lsb_result  input  1/ROB_IDX_W/DATA_W  LSB CDB snoop
- out_alu_enable  output  1  issue valid, registered
- out_alu_op, out_alu_pc, out_alu_imm, out_alu_rs, out_alu_rt, out_alu_reorder  output  OP_W/DATA_W×4/ROB_IDX_W  issued bundle, registered

Behaviour:
- Reset: all entries invalid; out_alu_enable=0; all out_alu_* buses 0; out_full=0.
- in_rdy==0: no state change and no CDB capture. out_alu_enable is driven 0 combinationally. Producers are stalled by the same in_rdy.
- out_full is combinational from the registered valid bits: 1 when all RS_DEPTH entries are valid. Dispatch while out_full==1 is ignored; the dispatcher must not do this.
- Allocation: dispatch writes the lowest-index invalid entry.
- Dispatch bypass: if an operand has r==0 and its q matches a CDB valid in the same cycle, the entry stores the CDB result with r=1.
- Wakeup: each edge, every valid entry with rj==0 and qj equal to a valid CDB tag captures that result and sets rj=1; the same applies to k. If both CDBs match the same tag, the ALU port wins (this cannot occur legally).
- Select: candidates are valid entries with rj&rk in the pre-edge registered state. The lowest index wins by default. A woken entry is therefore issuable no earlier than the next cycle.
- Issue: at the edge, the winner's fields are registered onto out_alu_*, out_alu_enable=1, and the entry is freed. With no candidate, out_alu_enable=0 and the buses hold their last values.
- Back-to-back: out_alu_enable may stay 1 on consecutive cycles; the consumer samples per cycle.
- Latency: a ready-operand dispatch at edge N gives out_alu_enable=1 after edge N+1 (1 cycle). A CDB wakeup at edge N gives issue at edge N+1.
- Same-cycle events: dispatch and issue may coincide. An entry freed by issue is not reallocated in that same cycle. Allocation uses pre-edge valid bits.
- Flush: at the edge with in_flush==1, all entries are invalidated, out_alu_enable=0, and dispatch/issue in that cycle are discarded. Flush has priority over everything except reset.
- Reset mid-operation: asserting in_rst drops all state immediately, asynchronously.

Optional Feature:
- RS_AGE_ORDER_EN defined: each entry carries an RS_IDX_W-bit age. Age is 0 at allocation and increments on every in_rdy cycle while waiting, saturating at all-ones. Select picks the largest age, with ties going to the lowest index.
- RS_AGE_ORDER_EN undefined: pure lowest-index select, and no age storage is synthesised.

Decomposition:
- Shared package: operator code constants (NOP, LUI, AUIPC, JAL, JALR, branches, I-type and R-type ops); width constants DATA_W, ROB_IDX_W, OP_W; the RS entry struct (valid, op, pc, imm, vj, vk, qj, qk, rj, rk, reorder, age).
- One natural sub-module, rs_select: a combinational priority/age picker producing found plus an index. It is reused for free-slot search with an inverted-valid input.

Test Plan:
- Reset then dispatch ADD with rj=rk=1, vj=5, vk=7, reorder=3 -> next cycle out_alu_enable=1, out_alu_op=ADD, rs=5, rt=7, reorder=3; entry freed.
- Dispatch SUB with qj=2 waiting, then ALU CDB tag 2 result 0x10 -> issue one cycle after the CDB with out_alu_rs=0x10.
- Dispatch whose qk=4 matches an LSB CDB valid in the same cycle -> entry stored ready, issues the next cycle with rt = CDB value.
- Fill 16 non-ready entries -> out_full=1 and a 17th dispatch is ignored; one wakeup plus issue -> out_full=0 the cycle after the entry is freed.
- Two entries ready together (idx 1 and 5) -> idx 1 issues first and idx 5 the next cycle. With RS_AGE_ORDER_EN, whichever entry is older issues first.
- in_flush with 3 waiting entries and a pending issue -> out_alu_enable=0 next cycle, out_full=0, and no later issue of the flushed tags.
